// File: rtl/gbt_rx_link.sv
// GBT downlink frame decoder: locks on the 7-word request frame, extracts write requests, registers TTC bits.
// Latency: req_en_o/frame_err_o one cycle after the deciding word; TTC outputs one cycle after input.
// Backpressure: none, one word accepted every clock; the request strobe must be consumed when it fires.
//
// Ports:
//   ttc_clk_40_i    40 MHz frame clock, rising edge
//   reset_i         async active-low reset; released synchronously through a 2-flop synchroniser
//   gbt_rx_data_i   [15:12] TTC {l1a, calpulse, resync, bc0}, [11:0] frame payload
//   req_en_o        one-cycle strobe, new request on req_addr_o/req_data_o/req_wr_o
//   req_addr_o/req_data_o/req_wr_o  last accepted request, held between strobes
//   frame_err_o     one-cycle strobe, frame check failed and lock dropped
//   l1a_o, calpulse_o, resync_o, bc0_o  registered TTC bits
//
// Build option: define GBT_RX_TTC_EN to build the TTC output registers; otherwise they are tied to 0.

module gbt_rx_link (
    input  logic        ttc_clk_40_i,
    input  logic        reset_i,
    input  logic [15:0] gbt_rx_data_i,
    output logic        req_en_o,
    output logic [31:0] req_data_o,
    output logic [31:0] req_addr_o,
    output logic        req_wr_o,
    output logic        frame_err_o,
    output logic        l1a_o,
    output logic        calpulse_o,
    output logic        resync_o,
    output logic        bc0_o
);

    localparam logic [11:0] END_MARKER = 12'hABC;

    typedef enum logic [2:0] {SYNC, HDR, A1, A2, D0, D1, D2, END} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [11:0] payload;
    logic        accept;
    logic        frame_err_nxt;

    logic        sh_wr_valid;
    logic        sh_wr_en;
    logic [31:0] sh_addr;
    logic [31:0] sh_data;

    assign payload = gbt_rx_data_i[11:0];

    // Reset asserts immediately but releases on a clock edge, so the FSM never
    // leaves reset half-way through a cycle.
    always_ff @(posedge ttc_clk_40_i or negedge reset_i) begin
        if (!reset_i) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge ttc_clk_40_i or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            SYNC: if (payload == END_MARKER) state_nxt = HDR;
            HDR: begin
                if (payload[9:8] != 2'b00) frame_err_nxt = 1'b1;
                else                       state_nxt = A1;
            end
            A1: state_nxt = A2;
            A2: state_nxt = D0;
            D0: begin
                if (payload[11:8] != 4'h0) frame_err_nxt = 1'b1;
                else                       state_nxt = D1;
            end
            D1: state_nxt = D2;
            D2: state_nxt = END;
            END: begin
                if (payload != END_MARKER) begin
                    frame_err_nxt = 1'b1;
                end else begin
                    // The marker doubles as the start of the next frame's lock.
                    state_nxt = HDR;
                    accept    = sh_wr_valid;
                end
            end
            default: state_nxt = SYNC;
        endcase
        if (frame_err_nxt) state_nxt = SYNC;
    end

    // Shadow capture: a frame is only visible on the outputs once its end marker checks out.
    always_ff @(posedge ttc_clk_40_i or negedge rst_n) begin
        if (!rst_n) begin
            sh_wr_valid <= 1'b0;
            sh_wr_en    <= 1'b0;
            sh_addr     <= '0;
            sh_data     <= '0;
        end else if (frame_err_nxt) begin
            sh_wr_valid <= 1'b0;
            sh_wr_en    <= 1'b0;
            sh_addr     <= '0;
            sh_data     <= '0;
        end else begin
            case (state)
                HDR: begin
                    sh_wr_valid     <= payload[11];
                    sh_wr_en        <= payload[10];
                    sh_addr[31:24]  <= payload[7:0];
                end
                A1: sh_addr[23:12] <= payload;
                A2: sh_addr[11:0]  <= payload;
                D0: sh_data[31:24] <= payload[7:0];
                D1: sh_data[23:12] <= payload;
                D2: sh_data[11:0]  <= payload;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ttc_clk_40_i or negedge rst_n) begin
        if (!rst_n) begin
            req_en_o    <= 1'b0;
            frame_err_o <= 1'b0;
            req_addr_o  <= '0;
            req_data_o  <= '0;
            req_wr_o    <= 1'b0;
        end else begin
            req_en_o    <= accept;
            frame_err_o <= frame_err_nxt;
            if (accept) begin
                req_addr_o <= sh_addr;
                req_data_o <= sh_data;
                req_wr_o   <= sh_wr_en;
            end
        end
    end

`ifdef GBT_RX_TTC_EN
    always_ff @(posedge ttc_clk_40_i or negedge rst_n) begin
        if (!rst_n) {l1a_o, calpulse_o, resync_o, bc0_o} <= 4'h0;
        else        {l1a_o, calpulse_o, resync_o, bc0_o} <= gbt_rx_data_i[15:12];
    end
`else
    logic unused_ttc_bits;
    assign unused_ttc_bits = ^gbt_rx_data_i[15:12];
    assign l1a_o      = 1'b0;
    assign calpulse_o = 1'b0;
    assign resync_o   = 1'b0;
    assign bc0_o      = 1'b0;
`endif

endmodule

// File: tb/tb_gbt_rx_link.sv
// Testbench for gbt_rx_link: table of per-word stimulus and expected outputs plus a mid-frame reset sequence.
// Latency: each record's expectations are checked one clock after its word is sampled.
// Backpressure: not applicable, one word driven per clock.

module tb_gbt_rx_link;

    logic        clk;
    logic        reset_i;
    logic [15:0] gbt_rx_data_i;
    logic        req_en_o;
    logic [31:0] req_data_o;
    logic [31:0] req_addr_o;
    logic        req_wr_o;
    logic        frame_err_o;
    logic        l1a_o, calpulse_o, resync_o, bc0_o;

    gbt_rx_link dut (
        .ttc_clk_40_i (clk),
        .reset_i      (reset_i),
        .gbt_rx_data_i(gbt_rx_data_i),
        .req_en_o     (req_en_o),
        .req_data_o   (req_data_o),
        .req_addr_o   (req_addr_o),
        .req_wr_o     (req_wr_o),
        .frame_err_o  (frame_err_o),
        .l1a_o        (l1a_o),
        .calpulse_o   (calpulse_o),
        .resync_o     (resync_o),
        .bc0_o        (bc0_o)
    );

    initial clk = 1'b0;
    always #12 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        req_en;
        logic        err;
        logic        wr;
        logic [3:0]  ttc;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    // Expected-behaviour tracking used while building the table.
    bit          m_locked;
    int          m_pos;
    logic [31:0] m_addr, m_data;
    logic        m_wr;

    task automatic check(input string tag, input int idx, input vec_t e);
        logic [70:0] act, exp;
        act = {req_en_o, frame_err_o, req_wr_o, l1a_o, calpulse_o, resync_o, bc0_o, req_addr_o, req_data_o};
        exp = {e.req_en, e.err, e.wr, e.ttc, e.addr, e.data};
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got en=%b err=%b wr=%b ttc=%h addr=%h data=%h, want en=%b err=%b wr=%b ttc=%h addr=%h data=%h",
                     tag, idx, act[70], act[69], act[68], act[67:64], act[63:32], act[31:0],
                     e.req_en, e.err, e.wr, e.ttc, e.addr, e.data);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input logic [31:0] fa, input logic [31:0] fd,
                             input logic fv, input logic fwr);
        vec_t v;
        bit   bad;
        v.word   = w;
        v.req_en = 1'b0;
        v.err    = 1'b0;
`ifdef GBT_RX_TTC_EN
        v.ttc    = w[15:12];
`else
        v.ttc    = 4'h0;
`endif
        if (!m_locked) begin
            if (w[11:0] == 12'hABC) begin
                m_locked = 1'b1;
                m_pos    = 0;
            end
        end else begin
            bad = (m_pos == 0 && w[9:8] != 2'b00) ||
                  (m_pos == 3 && w[11:8] != 4'h0) ||
                  (m_pos == 6 && w[11:0] != 12'hABC);
            if (bad) begin
                v.err    = 1'b1;
                m_locked = 1'b0;
            end else if (m_pos == 6) begin
                m_pos = 0;
                if (fv) begin
                    v.req_en = 1'b1;
                    m_addr   = fa;
                    m_data   = fd;
                    m_wr     = fwr;
                end
            end else begin
                m_pos++;
            end
        end
        v.addr = m_addr;
        v.data = m_data;
        v.wr   = m_wr;
        vecs.push_back(v);
    endtask

    task automatic add_frame(input logic [31:0] a, input logic [31:0] d, input logic valid, input logic wr,
                             input logic [3:0] ttc_a, input logic [3:0] ttc_b,
                             input int bad_idx, input logic [11:0] bad_pl);
        logic [11:0] pl [7];
        pl[0] = {valid, wr, 2'b00, a[31:24]};
        pl[1] = a[23:12];
        pl[2] = a[11:0];
        pl[3] = {4'h0, d[31:24]};
        pl[4] = d[23:12];
        pl[5] = d[11:0];
        pl[6] = 12'hABC;
        if (bad_idx >= 0) pl[bad_idx] = bad_pl;
        for (int i = 0; i < 7; i++)
            push_word({(i % 2 == 0) ? ttc_a : ttc_b, pl[i]}, a, d, valid, wr);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_addr   = '0;
        m_data   = '0;
        m_wr     = 1'b0;
        vecs.delete();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            gbt_rx_data_i = vecs[i].word;
            @(negedge clk);
            check(tag, i, vecs[i]);
        end
    endtask

    vec_t zero_v;

    initial begin
        zero_v = '{word: 16'h0, req_en: 1'b0, err: 1'b0, wr: 1'b0, ttc: 4'h0, addr: 32'h0, data: 32'h0};
        reset_i       = 1'b0;
        gbt_rx_data_i = 16'hFABC;
        repeat (3) @(negedge clk);
        check("reset_state", 0, zero_v);
        reset_i = 1'b1;

        // Lock, steady traffic, hold behaviour, in-frame markers and every error path.
        model_reset();
        for (int i = 0; i < 4; i++) push_word(16'h0000, '0, '0, 1'b0, 1'b0);
        push_word(16'h0ABC, '0, '0, 1'b0, 1'b0);
        add_frame(32'h40000000, 32'h12345678, 1'b1, 1'b1, 4'hF, 4'hF, -1, 12'h0);
        add_frame(32'h40000000, 32'h12345678, 1'b1, 1'b1, 4'hF, 4'hF, -1, 12'h0);
        add_frame(32'h89ABCDEF, 32'h0F1E2D3C, 1'b1, 1'b0, 4'h0, 4'hF, -1, 12'h0);
        add_frame(32'h13572468, 32'h2468ACE0, 1'b0, 1'b1, 4'hF, 4'h0, -1, 12'h0);
        add_frame(32'h00ABCABC, 32'hABCABCAB, 1'b1, 1'b1, 4'hA, 4'h5, -1, 12'h0);
        add_frame(32'h11112222, 32'h33334444, 1'b1, 1'b1, 4'h0, 4'h0, 6, 12'hABD);
        add_frame(32'h55556666, 32'h77778888, 1'b1, 1'b1, 4'h3, 4'hC, -1, 12'h0);
        add_frame(32'h9999AAAA, 32'hBBBBCCCC, 1'b1, 1'b0, 4'h0, 4'hF, -1, 12'h0);
        add_frame(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1, 4'h0, 4'h0, 3, 12'h1CA);
        add_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1, 4'h0, 4'h0, -1, 12'h0);
        add_frame(32'h12345678, 32'h01020304, 1'b1, 1'b1, 4'h0, 4'h0, 0, 12'hE12);
        add_frame(32'hFEDCBA98, 32'h76543210, 1'b1, 1'b0, 4'hF, 4'hF, -1, 12'h0);
        run_table("frames");

        // Reset in the middle of a frame: everything clears at once.
        gbt_rx_data_i = 16'hFCAB;
        @(negedge clk);
        gbt_rx_data_i = 16'hF345;
        @(posedge clk);
        #3;
        reset_i = 1'b0;
        #1;
        check("reset_async", 0, zero_v);
        @(negedge clk);
        check("reset_held", 0, zero_v);
        reset_i = 1'b1;

        // After release the first frame only relocks; the next one is accepted.
        model_reset();
        for (int i = 0; i < 4; i++) push_word(16'h0000, '0, '0, 1'b0, 1'b0);
        add_frame(32'h31415926, 32'h53589793, 1'b1, 1'b1, 4'hF, 4'h0, -1, 12'h0);
        add_frame(32'h27182818, 32'h28459045, 1'b1, 1'b1, 4'h0, 4'hF, -1, 12'h0);
        run_table("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

endmodule
